// File: rtl/eth_arb_pkg.sv
// Shared types for the Ethernet TX arbiter and future RX/queue arbiters.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_arb_state_t;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;
  } axis_beat_t;

  // Wide enough for any gap length up to 65535 cycles.
  localparam int unsigned GapCntW = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IdxW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = NUM_SRC; off >= 1; off--) begin
      cand = IdxW'((32'(last) + off) % NUM_SRC);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter sharing one 64-bit AXI-Stream MAC TX port.
module eth_tx_arb
  import eth_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned GAP_CYCLES = 0,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned IdxW       = $clog2(NUM_SRC)
) (
  input  logic                     clk156,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC-1:0]       s_tvalid,
  output logic [NUM_SRC-1:0]       s_tready,
  input  logic [NUM_SRC*64-1:0]    s_tdata,
  input  logic [NUM_SRC*8-1:0]     s_tkeep,
  input  logic [NUM_SRC-1:0]       s_tlast,
  input  logic [NUM_SRC-1:0]       s_tuser,
  input  logic                     m_tready,
  output logic                     m_tvalid,
  output logic [63:0]              m_tdata,
  output logic [7:0]               m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tuser,
  output logic [IdxW-1:0]          grant_idx,
  output logic                     busy,
  output logic [NUM_SRC*CNT_W-1:0] frame_cnt
);

  tx_arb_state_t        state_q, state_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [GapCntW-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]     cnt_q [NUM_SRC];

  axis_beat_t           src_beat [NUM_SRC];
  axis_beat_t           sel_beat;
  logic                 sel_valid;
  logic [NUM_SRC-1:0]   req;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 frame_done;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_beat[i] = {s_tdata[64*i +: 64], s_tkeep[8*i +: 8], s_tlast[i], s_tuser[i]};
    assign frame_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end

  assign req       = s_tvalid & src_en;
  assign sel_beat  = src_beat[grant_q];
  assign sel_valid = s_tvalid[grant_q];
  assign frame_done = (state_q == TX_SEND) && sel_valid && m_tready && sel_beat.tlast;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q <= TX_IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_SRC - 1);
      gap_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      if (frame_done) begin
        cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      TX_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (frame_done) begin
          last_d  = grant_q;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? TX_GAP : TX_IDLE;
        end
      end
      TX_GAP: begin
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
          gap_d   = '0;
          state_d = TX_IDLE;
        end else begin
          gap_d = gap_q + GapCntW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Beat path is purely combinational from the granted source.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = sel_beat.tdata;
    m_tkeep  = sel_beat.tkeep;
    m_tlast  = sel_beat.tlast;
    m_tuser  = sel_beat.tuser;
    s_tready = '0;
    if (state_q == TX_SEND) begin
      m_tvalid          = sel_valid;
      s_tready[grant_q] = m_tready;
    end
  end

  assign busy      = (state_q == TX_SEND);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench: per-source frame queues, frame-level round-robin model, beat monitor.
module tb_eth_tx_arb;
  import eth_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 32;

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic            reset;
  logic [N-1:0]    src_en, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [N*64-1:0] s_tdata;
  logic [N*8-1:0]  s_tkeep;
  logic            m_tready, m_tvalid, m_tlast, m_tuser;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [N*CW-1:0] frame_cnt;

  // Second instance with a 5-cycle gap: sources 1 and 3 send single-beat frames forever.
  logic [N-1:0]    g5_en, g5_tvalid, g5_s_tready, g5_tlast, g5_tuser;
  logic [N*64-1:0] g5_tdata;
  logic [N*8-1:0]  g5_tkeep;
  logic            g5_m_tvalid, g5_m_tlast, g5_m_tuser;
  logic [63:0]     g5_m_tdata;
  logic [7:0]      g5_m_tkeep;
  logic [1:0]      g5_grant;
  logic            g5_busy;
  logic [N*CW-1:0] g5_cnt;

  eth_tx_arb #(.NUM_SRC(N), .GAP_CYCLES(0), .CNT_W(CW)) dut (
    .clk156(clk156), .reset(reset), .src_en(src_en), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .grant_idx(grant_idx), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  eth_tx_arb #(.NUM_SRC(N), .GAP_CYCLES(5), .CNT_W(CW)) dut_g5 (
    .clk156(clk156), .reset(reset), .src_en(g5_en), .s_tvalid(g5_tvalid),
    .s_tready(g5_s_tready), .s_tdata(g5_tdata), .s_tkeep(g5_tkeep), .s_tlast(g5_tlast),
    .s_tuser(g5_tuser), .m_tready(1'b1), .m_tvalid(g5_m_tvalid), .m_tdata(g5_m_tdata),
    .m_tkeep(g5_m_tkeep), .m_tlast(g5_m_tlast), .m_tuser(g5_m_tuser), .grant_idx(g5_grant),
    .busy(g5_busy), .frame_cnt(g5_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  longint      cyc   = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  axis_beat_t drv_q [N][$];
  axis_beat_t exp_q [N][$];
  int         rdy_mode = 0;
  bit         bubbles  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- source driver ----------------
  initial begin : driver
    logic [N-1:0] hs;
    bit           in_frm [N];
    axis_beat_t   b;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b1;
    hs = '0;
    for (int i = 0; i < N; i++) in_frm[i] = 1'b0;
    forever begin
      @(negedge clk156);
      hs = s_tvalid & s_tready;
      @(posedge clk156);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) begin
          s_tvalid[i] = 1'b0;
          in_frm[i]   = 1'b0;
        end else begin
          if (hs[i]) begin
            in_frm[i] = !s_tlast[i];
            if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            s_tvalid[i] = 1'b0;
          end
          // First beat of a frame is never delayed; later beats may bubble.
          if (!s_tvalid[i] && drv_q[i].size() > 0)
            s_tvalid[i] = !in_frm[i] || !bubbles || ($urandom_range(0, 3) != 0);
          if (s_tvalid[i]) begin
            b = drv_q[i][0];
            s_tdata[64*i +: 64] = b.tdata;
            s_tkeep[8*i +: 8]   = b.tkeep;
            s_tlast[i]          = b.tlast;
            s_tuser[i]          = b.tuser;
          end
        end
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor + reference model ----------------
  int     last_g = N - 1;
  bit     act    = 1'b0;
  int     cur    = 0;
  int     beat_no = 0;
  int     cnt_m [N];
  longint end_cyc = 0;
  int     order_q [$];
  int     gap_q [$];
  bit     prev_stall = 1'b0;
  logic [63:0] prev_data;

  function automatic int rr_model();
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (last_g + k) % N;
      if (src_en[s] && exp_q[s].size() > 0) return s;
    end
    return -1;
  endfunction

  always @(negedge clk156) begin : monitor
    logic [N-1:0] er;
    axis_beat_t   e;
    if (reset) begin
      act = 1'b0; last_g = N - 1; prev_stall = 1'b0; beat_no = 0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else begin
      if (m_tvalid && !act) begin
        cur = rr_model();
        if (cur < 0) begin
          timeout("frame start with no eligible pending source");
          cur = 0;
        end
        act = 1'b1;
        beat_no = 0;
        order_q.push_back(cur);
        gap_q.push_back(int'(cyc - end_cyc));
      end
      er = '0;
      if (act) begin
        if (m_tready) er[cur] = 1'b1;
        check("grant_idx", grant_idx, cur);
        check("s_tready in frame", s_tready, er);
        check("busy in frame", busy, 1'b1);
      end else begin
        check("s_tready idle", s_tready, er);
        check("busy idle", busy, 1'b0);
      end
      if (prev_stall && m_tvalid) check("tdata held while stalled", m_tdata, prev_data);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (m_tvalid && m_tready) begin
        if (exp_q[cur].size() == 0) begin
          timeout("beat with empty expected queue");
        end else begin
          e = exp_q[cur].pop_front();
          check("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
        end
        beat_no++;
        if (m_tlast) begin
          act = 1'b0;
          cnt_m[cur]++;
          last_g  = cur;
          end_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_frame(input int s, input int len, input logic [7:0] lastkeep);
    axis_beat_t x;
    for (int b = 0; b < len; b++) begin
      x.tdata        = {$urandom(), $urandom()};
      x.tdata[63:56] = 8'(s);
      x.tkeep        = (b == len - 1) ? lastkeep : 8'hFF;
      x.tlast        = (b == len - 1);
      x.tuser        = 1'($urandom_range(0, 1));
      drv_q[s].push_back(x);
      exp_q[s].push_back(x);
    end
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    forever begin
      @(negedge clk156);
      #1;
      if (q_empty() && !act && !m_tvalid) break;
      if (++n > budget) begin
        timeout(tag);
        break;
      end
    end
  endtask

  task automatic check_cnts(input string tag);
    for (int i = 0; i < N; i++) check(tag, frame_cnt[CW*i +: CW], cnt_m[i]);
  endtask

  // Called just after a negedge; checks the reset state on the following negedge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk156);
    #2;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    @(negedge clk156);
    check("reset m_tvalid", m_tvalid, 1'b0);
    check("reset s_tready", s_tready, '0);
    check("reset busy", busy, 1'b0);
    check("reset grant_idx", grant_idx, 0);
    check("reset frame_cnt", frame_cnt, '0);
    check("reset g5 frame_cnt", g5_cnt, '0);
    @(posedge clk156);
    #3;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    longint t0, t1;
    int     base1, nfr, nord;
    bit     ok;
    int     g5_src [$];
    longint g5_cyc [$];

    reset = 1'b1;
    src_en = '1;
    g5_en = '1; g5_tvalid = 4'b1010; g5_tlast = '1; g5_tuser = '0; g5_tkeep = '1;
    for (int i = 0; i < N; i++) g5_tdata[64*i +: 64] = 64'(i);
    repeat (3) @(negedge clk156);
    #1;
    do_reset();

    // Single 8-beat frame from source 0.
    push_frame(0, 8, 8'h0F);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk156); #1;
      ok = s_tvalid[0];
    end
    t0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk156); #1;
      ok = m_tvalid;
    end
    if (!ok) timeout("first beat");
    t1 = cyc;
    check("first-beat latency", 64'(t1 - t0), 1);
    wait_idle(100, "single frame drain");
    check("src0 count after one frame", frame_cnt[0 +: CW], 1);
    check("idle after frame", busy, 1'b0);

    // Fairness: all sources, two frames each, from a fresh reset.
    do_reset();
    order_q.delete();
    gap_q.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push_frame(s, 4, 8'hFF);
    wait_idle(300, "fairness drain");
    check("fairness frame total", order_q.size(), 8);
    for (int k = 0; k < order_q.size(); k++) check("rr order", order_q[k], k % N);
    for (int k = 1; k < gap_q.size(); k++) check("frame spacing gap0", gap_q[k], 2);
    for (int i = 0; i < N; i++) check("fairness count", frame_cnt[CW*i +: CW], 2);

    // Toggling MAC ready during source 2's frame.
    rdy_mode = 1;
    push_frame(2, 8, 8'hFF);
    wait_idle(200, "tready toggle drain");
    rdy_mode = 0;
    check("src2 count after toggle frame", frame_cnt[2*CW +: CW], 3);

    // Randomized rounds with source bubbles and random MAC backpressure.
    rdy_mode = 2;
    bubbles  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++) begin
        nfr = $urandom_range(0, 3);
        for (int f = 0; f < nfr; f++)
          push_frame(s, $urandom_range(1, 6), 8'($urandom_range(1, 255)));
      end
      wait_idle(3000, "random drain");
      check_cnts("random counts");
    end
    rdy_mode = 0;
    bubbles  = 1'b0;

    // Disable source 1 during beat 3 of its first frame.
    base1 = cnt_m[1];
    for (int f = 0; f < 3; f++) begin
      push_frame(0, 6, 8'hFF);
      push_frame(1, 6, 8'hFF);
    end
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk156); #1;
      ok = act && (cur == 1) && (beat_no >= 3);
    end
    if (!ok) timeout("src1 beat 3");
    src_en[1] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk156); #1;
      ok = (exp_q[0].size() == 0) && !act && !m_tvalid;
    end
    if (!ok) timeout("src0 drain with src1 disabled");
    nord = order_q.size();
    repeat (20) @(negedge clk156);
    #1;
    check("no grant while disabled", order_q.size(), nord);
    check("src1 frame finished", frame_cnt[CW +: CW], base1 + 1);
    check("src1 frames held back", exp_q[1].size(), 12);
    src_en = '1;
    wait_idle(300, "src1 re-enable drain");
    check_cnts("src_en counts");

    // Reset in the middle of a frame, then source 0 must win first.
    push_frame(0, 8, 8'hFF);
    push_frame(1, 8, 8'hFF);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk156); #1;
      ok = act && (beat_no >= 3);
    end
    if (!ok) timeout("beat 4 before reset");
    do_reset();
    order_q.delete();
    push_frame(2, 3, 8'h01);
    push_frame(1, 3, 8'h03);
    push_frame(0, 3, 8'h07);
    wait_idle(200, "post-reset drain");
    check("post-reset frames", order_q.size(), 3);
    for (int k = 0; k < order_q.size(); k++) check("post-reset order", order_q[k], k);
    check_cnts("post-reset counts");

    // Gap instance: alternate 1,3 with exactly 6 dead cycles between frames.
    for (int k = 0; k < 70; k++) begin
      @(negedge clk156);
      if (g5_m_tvalid) begin
        g5_src.push_back(int'(g5_m_tdata[7:0]));
        g5_cyc.push_back(cyc);
        check("g5 beat sideband",
              {g5_m_tlast, g5_m_tkeep, g5_m_tuser, g5_grant, g5_busy, g5_s_tready},
              {1'b1, 8'hFF, 1'b0, 2'(g5_m_tdata[7:0]), 1'b1, 4'(1 << g5_m_tdata[7:0])});
      end
    end
    check("g5 beats observed", g5_src.size() >= 8, 1'b1);
    for (int k = 1; k < g5_src.size(); k++) begin
      check("g5 alternation", g5_src[k], (g5_src[k-1] == 1) ? 3 : 1);
      check("g5 spacing", 64'(g5_cyc[k] - g5_cyc[k-1]), 7);
    end
    check("g5 idle sources", {g5_cnt[0 +: CW], g5_cnt[2*CW +: CW]}, '0);
    check("g5 balanced", (g5_cnt[CW +: CW] - g5_cnt[3*CW +: CW] <= 1) ||
                         (g5_cnt[3*CW +: CW] - g5_cnt[CW +: CW] <= 1), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
